uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter that answers the single-cycle RISC-V core's data-memory bus.
- The core issues stores and loads on the same `Mem_Write_i`/`Mem_Read_i`/`Address_i`/`Write_Data_i` bus that feeds data memory; this block decodes a small address window and responds to those accesses.
- Stored bytes are queued in a small TX FIFO and serialized 8N1, LSB first, on `Tx_o`.
- Loads return status combinationally, so single-cycle loads complete in the same cycle. The top level muxes `Read_Data_o` against data memory using `Hit_o`.

## Interface
Parameters
- `DATA_WIDTH`, 32: bus data width.
- `BASE_ADDR`, 32'h1001_0000: window base; must be 8-byte aligned.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of 2 and ≥2.

Ports
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Mem_Write_i`  in  1  store strobe from core.
- `Mem_Read_i`  in  1  load strobe from core.
- `Address_i`  in  32  byte address.
- `Write_Data_i`  in  DATA_WIDTH  store data.
- `Read_Data_o`  out  DATA_WIDTH  load data (combinational).
- `Hit_o`  out  1  `Address_i[31:3] == BASE_ADDR[31:3]` (combinational).
- `Tx_o`  out  1  serial line, idles high.
- `Busy_o`  out  1  frame in progress (state ≠ IDLE).

## Operation
Address decode
- `Address_i[1:0]` ignored; `Address_i[2]` selects the register.
- Offset 0x0 is TXDATA.
- Offset 0x4 is STATUS.

Register map
- TXDATA write:
  - pushes `Write_Data_i[7:0]`; upper bits are ignored;
  - if the FIFO is full, the byte is dropped and sticky `overflow` is set.
- TXDATA read returns 0.
- STATUS read fields:
  - bit0 `full`;
  - bit1 `empty`;
  - bit2 `busy`;
  - bit3 `overflow`;
  - bits[7:4] FIFO count;
  - all other bits 0.
- STATUS write: `Write_Data_i[3]=1` clears `overflow`; all other bits are ignored.

Read path
- `Read_Data_o` is 0 unless `Mem_Read_i && Hit_o`.
- Accesses with `Hit_o=0` have no effect.

FIFO
- Full is evaluated on pre-edge state: a push while full is dropped even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: both take effect and the count is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.
- Count is `$clog2(FIFO_DEPTH)+1` bits, zero-extended into STATUS[7:4].

TX FSM states and transitions
- IDLE
  - `Tx_o=1`.
  - If FIFO is non-empty: pop the head into the shift register, load the baud counter, go to START.
- START
  - `Tx_o=0` for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA
  - `Tx_o=shift[0]` for `CLKS_PER_BIT` cycles, then shift right.
  - After bit 7, go to STOP.
- STOP
  - `Tx_o=1` for `CLKS_PER_BIT` cycles.
  - At the end: if FIFO is non-empty, pop and go directly to START (gapless); else go to IDLE.
- The baud counter counts down from `CLKS_PER_BIT-1`; each state advances when the counter reaches 0.

Reset (asynchronous, active-low)
- `Tx_o=1`, state IDLE, FIFO empty, `overflow=0`, `Busy_o=0`.
- `Read_Data_o` and `Hit_o` follow their inputs combinationally.
- Reset mid-frame truncates the frame immediately (line forced high) and discards FIFO contents.

## Timing
- Store to TXDATA at edge N:
  - the byte is in the FIFO after edge N;
  - if IDLE, it is popped at edge N+1;
  - `Tx_o` falls and `Busy_o` rises right after edge N+1.
- Frame length is exactly `10*CLKS_PER_BIT` cycles; back-to-back frames have no idle gap.
- `Busy_o` deasserts after the last stop-bit cycle if the FIFO is empty.
- STATUS reflects register state as of the last edge; a same-cycle store is not visible to a same-cycle load.

## Structure
- Package `uart_tx_mmio_pkg`:
  - state enum {IDLE, START, DATA, STOP};
  - register offsets `TXDATA_OFS=0`, `STATUS_OFS=4`;
  - STATUS bit positions.
- Sub-module `tx_fifo`:
  - synchronous FIFO parameterized by width 8 and `FIFO_DEPTH`;
  - push/pop/full/empty/count ports;
  - reset clears the pointers.
- Top block contains the decode, the STATUS mux, and the FSM with its baud counter and shift register.

## Test plan
All scenarios use `CLKS_PER_BIT=4`, `FIFO_DEPTH=4`.
- **Reset:** assert `reset=0` mid-idle, then release; read STATUS at BASE+4 → `Read_Data_o=32'h0000_0002`, `Tx_o=1`, `Busy_o=0`.
- **Single frame:** store 32'hFFFF_FF55 to BASE.
  - `Tx_o` goes low 1 cycle later for 4 cycles.
  - Then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles.
  - `Busy_o` is high for exactly 40 cycles.
- **Overflow:** store 0x41..0x46 on 6 consecutive cycles.
  - The sixth store is dropped; STATUS=`0x4D` (count 4, overflow, busy, full).
  - Exactly 5 gapless frames (0x41..0x45) are sent.
  - Storing 0x8 to BASE+4 clears bit3.
- **Decode isolation:**
  - a store to BASE+8 gives `Hit_o=0`, no push, FIFO count unchanged;
  - a load of BASE with `Mem_Read_i=1` gives `Read_Data_o=0`;
  - a load of BASE+4 with `Mem_Read_i=0` gives `Read_Data_o=0`.
- **Reset mid-frame:** assert `reset=0` during DATA bit 3 with 2 bytes queued.
  - `Tx_o=1` immediately; STATUS=`0x02` after release.
  - No further frames are sent.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 4;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous TX byte FIFO: a push while full is dropped even if a pop happens in the same cycle.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter on the core's data-memory bus: TXDATA/STATUS decode, FIFO, 8N1 serializer.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Mem_Write_i,
    input  logic                  Mem_Read_i,
    input  logic [31:0]           Address_i,
    input  logic [DATA_WIDTH-1:0] Write_Data_i,
    output logic [DATA_WIDTH-1:0] Read_Data_o,
    output logic                  Hit_o,
    output logic                  Tx_o,
    output logic                  Busy_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    logic            is_status;
    logic            wr_txdata;
    logic            wr_status;
    logic            overflow;
    logic            fifo_pop;
    logic [7:0]      fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    tx_state_t       state, state_next;
    logic [BW-1:0]   baud_cnt, baud_cnt_next;
    logic [2:0]      bit_idx, bit_idx_next;
    logic [7:0]      shift, shift_next;

    logic [DATA_WIDTH-1:0] count_ext;
    logic [DATA_WIDTH-1:0] status;
    logic                  unused_bits;

    assign Hit_o     = (Address_i[31:3] == BASE_ADDR[31:3]);
    assign is_status = (Address_i[2] == STATUS_OFS[2]);
    assign wr_txdata = Mem_Write_i && Hit_o && (Address_i[2] == TXDATA_OFS[2]);
    assign wr_status = Mem_Write_i && Hit_o && is_status;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (Write_Data_i[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sticky overflow: a store that finds the FIFO full is lost and flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (wr_txdata && fifo_full) begin
            overflow <= 1'b1;
        end else if (wr_status && Write_Data_i[ST_OVF_BIT]) begin
            overflow <= 1'b0;
        end
    end

    assign count_ext = DATA_WIDTH'(fifo_count);

    always_comb begin
        status = '0;
        status[ST_FULL_BIT]  = fifo_full;
        status[ST_EMPTY_BIT] = fifo_empty;
        status[ST_BUSY_BIT]  = Busy_o;
        status[ST_OVF_BIT]   = overflow;
        status[ST_COUNT_LSB +: ST_COUNT_W] = count_ext[ST_COUNT_W-1:0];
    end

    // TXDATA reads as zero, so only a STATUS hit drives the bus.
    assign Read_Data_o = (Mem_Read_i && Hit_o && is_status) ? status : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        fifo_pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shift_next    = fifo_head;
                    baud_cnt_next = BAUD_RELOAD;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    baud_cnt_next = BAUD_RELOAD;
                    bit_idx_next  = '0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt - BW'(1);
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_cnt_next = BAUD_RELOAD;
                    shift_next    = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt - BW'(1);
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    // Chain straight into the next start bit when more bytes wait.
                    if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        shift_next    = fifo_head;
                        baud_cnt_next = BAUD_RELOAD;
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt - BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Tx_o = 1'b1;
        case (state)
            START:   Tx_o = 1'b0;
            DATA:    Tx_o = shift[0];
            default: Tx_o = 1'b1;
        endcase
    end

    assign Busy_o = (state != IDLE);

    assign unused_bits = ^{Address_i[1:0], Write_Data_i[DATA_WIDTH-1:8],
                           count_ext[DATA_WIDTH-1:ST_COUNT_W]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Mem_Write_i;
    logic        Mem_Read_i;
    logic [31:0] Address_i;
    logic [31:0] Write_Data_i;
    logic [31:0] Read_Data_o;
    logic        Hit_o;
    logic        Tx_o;
    logic        Busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] tx_cap;
    logic [255:0] busy_cap;
    logic [31:0]  st;
    int           cnt_a;
    int           cnt_b;

    uart_tx_mmio #(
        .DATA_WIDTH   (32),
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Mem_Write_i  (Mem_Write_i),
        .Mem_Read_i   (Mem_Read_i),
        .Address_i    (Address_i),
        .Write_Data_i (Write_Data_i),
        .Read_Data_o  (Read_Data_o),
        .Hit_o        (Hit_o),
        .Tx_o         (Tx_o),
        .Busy_o       (Busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        Mem_Write_i  = 1'b1;
        Address_i    = addr;
        Write_Data_i = data;
        tick();
        Mem_Write_i  = 1'b0;
        Address_i    = '0;
        Write_Data_i = '0;
    endtask

    task automatic read_status(output logic [31:0] v);
        Address_i  = BASE + 32'd4;
        Mem_Read_i = 1'b1;
        #1;
        v          = Read_Data_o;
        Mem_Read_i = 1'b0;
        Address_i  = '0;
    endtask

    // 8N1 frame, LSB first, each bit held for 4 clocks; bit k is the line after the k-th edge.
    function automatic logic [39:0] exp_frame(input logic [7:0] b);
        logic [39:0] f;
        for (int k = 0; k < 40; k++) begin
            int j;
            j = k / 4;
            if (j == 0)      f[k] = 1'b0;
            else if (j == 9) f[k] = 1'b1;
            else             f[k] = b[j-1];
        end
        return f;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        Mem_Write_i  = 1'b0;
        Mem_Read_i   = 1'b0;
        Address_i    = '0;
        Write_Data_i = '0;
        tx_cap       = '0;
        busy_cap     = '0;

        // Reset
        repeat (3) tick();
        check("tx_in_reset", 64'(Tx_o), 64'd1);
        #2 reset = 1'b1;
        tick();
        read_status(st);
        check("rst_status", 64'(st), 64'h2);
        check("rst_tx", 64'(Tx_o), 64'd1);
        check("rst_busy", 64'(Busy_o), 64'd0);

        // Single frame of 0x55
        store(BASE, 32'hFFFF_FF55);
        read_status(st);
        check("single_status_queued", 64'(st), 64'h10);
        check("single_tx_pre", 64'(Tx_o), 64'd1);
        check("single_busy_pre", 64'(Busy_o), 64'd0);
        for (int k = 0; k < 44; k++) begin
            tick();
            tx_cap[k]   = Tx_o;
            busy_cap[k] = Busy_o;
        end
        check("single_frame_bits", 64'(tx_cap[39:0]), 64'(exp_frame(8'h55)));
        check("single_frame_tail", 64'(tx_cap[43:40]), 64'hF);
        cnt_a = 0;
        for (int k = 0; k < 44; k++) cnt_a += int'(busy_cap[k]);
        check("single_busy_cycles", 64'(cnt_a), 64'd40);
        check("single_busy_end", 64'(busy_cap[40]), 64'd0);

        // Overflow: six consecutive stores into a 4-deep FIFO
        tx_cap   = '1;
        busy_cap = '0;
        for (int i = 0; i < 6; i++) begin
            store(BASE, 32'h41 + 32'(i));
            if (i >= 1) begin
                tx_cap[i-1]   = Tx_o;
                busy_cap[i-1] = Busy_o;
            end
        end
        read_status(st);
        check("ovf_status", 64'(st), 64'h4D);
        for (int k = 5; k < 210; k++) begin
            tick();
            tx_cap[k]   = Tx_o;
            busy_cap[k] = Busy_o;
        end
        for (int f = 0; f < 5; f++) begin
            check($sformatf("ovf_frame%0d", f), 64'(tx_cap[40*f +: 40]), 64'(exp_frame(8'h41 + 8'(f))));
        end
        check("ovf_idle_tail", 64'(tx_cap[209:200]), 64'h3FF);
        cnt_a = 0;
        for (int k = 0; k < 210; k++) cnt_a += int'(busy_cap[k]);
        check("ovf_busy_cycles", 64'(cnt_a), 64'd200);
        read_status(st);
        check("ovf_status_after", 64'(st), 64'h0A);
        store(BASE + 32'd4, 32'h8);
        read_status(st);
        check("ovf_cleared", 64'(st), 64'h02);

        // Decode isolation
        Mem_Write_i  = 1'b1;
        Address_i    = BASE + 32'd8;
        Write_Data_i = 32'h77;
        #1;
        check("iso_hit_base8", 64'(Hit_o), 64'd0);
        tick();
        Mem_Write_i  = 1'b0;
        Address_i    = '0;
        Write_Data_i = '0;
        read_status(st);
        check("iso_no_push", 64'(st), 64'h02);
        tick();
        read_status(st);
        check("iso_still_idle", 64'(st), 64'h02);
        Address_i  = BASE;
        Mem_Read_i = 1'b1;
        #1;
        check("iso_read_txdata", 64'(Read_Data_o), 64'd0);
        check("iso_hit_base", 64'(Hit_o), 64'd1);
        Address_i  = BASE + 32'd4;
        Mem_Read_i = 1'b0;
        #1;
        check("iso_no_read_strobe", 64'(Read_Data_o), 64'd0);
        Address_i = '0;

        // Reset mid-frame during DATA bit 3 of 0xA5 with two bytes queued
        store(BASE, 32'hA5);
        store(BASE, 32'h11);
        store(BASE, 32'h22);
        repeat (16) tick();
        check("mid_tx_bit3", 64'(Tx_o), 64'd0);
        read_status(st);
        check("mid_status", 64'(st), 64'h24);
        reset = 1'b0;
        #1;
        check("mid_rst_tx", 64'(Tx_o), 64'd1);
        check("mid_rst_busy", 64'(Busy_o), 64'd0);
        repeat (2) tick();
        #2 reset = 1'b1;
        tick();
        read_status(st);
        check("mid_status_after", 64'(st), 64'h02);
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (Tx_o !== 1'b1)  cnt_a++;
            if (Busy_o !== 1'b0) cnt_b++;
        end
        check("mid_no_tx_low", 64'(cnt_a), 64'd0);
        check("mid_no_busy", 64'(cnt_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
